// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage operand/producer information going into the forwarding/hazard controller,
// together with the registered forwarding selects, stall and stall-count coming out of it.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             Freeze;
  logic             Flush;
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_RegWrite;
  logic             ID_MemRead;
  logic [4:0]       ID_WriteReg;
  logic [1:0]       AluSrcA_Sel;
  logic [1:0]       AluSrcB_Sel;
  logic             Stall;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output Freeze, Flush, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt,
           ID_RegWrite, ID_MemRead, ID_WriteReg,
    input  AluSrcA_Sel, AluSrcB_Sel, Stall, StallCount
  );

  modport slave (
    input  Freeze, Flush, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt,
           ID_RegWrite, ID_MemRead, ID_WriteReg,
    output AluSrcA_Sel, AluSrcB_Sel, Stall, StallCount
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for a 5-stage MIPS pipeline.
// Tracks the EX and MEM producers itself and registers the EX operand-mux selects.
module fwd_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               rst,
  fwd_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic             ex_rw_q, ex_rw_d;
  logic             ex_mr_q, ex_mr_d;
  logic [4:0]       ex_wr_q, ex_wr_d;
  logic             mem_rw_q;
  logic [4:0]       mem_wr_q;
  logic [1:0]       sel_a_q, sel_a_d;
  logic [1:0]       sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;
  logic [1:0]       fwd_a, fwd_b;

  // EX match wins over MEM so the youngest producer is forwarded; an EX load is
  // never forwarded from here because it stalls instead.
  function automatic logic [1:0] fwd_sel(
    input logic       use_x,
    input logic [4:0] x,
    input logic       erw,
    input logic       emr,
    input logic [4:0] ewr,
    input logic       mrw,
    input logic [4:0] mwr
  );
    logic match;
    match = use_x && (x != 5'd0);
    if (match && erw && (ewr == x) && !emr) return SEL_MEM;
    if (match && mrw && (mwr == x))         return SEL_WB;
    return SEL_REG;
  endfunction

  always_comb begin
    stall = !bus.Flush && ex_mr_q && ex_rw_q && (ex_wr_q != 5'd0) &&
            ((bus.ID_UsesRs && (bus.ID_rs == ex_wr_q)) ||
             (bus.ID_UsesRt && (bus.ID_rt == ex_wr_q)));

    fwd_a = fwd_sel(bus.ID_UsesRs, bus.ID_rs, ex_rw_q, ex_mr_q, ex_wr_q, mem_rw_q, mem_wr_q);
    fwd_b = fwd_sel(bus.ID_UsesRt, bus.ID_rt, ex_rw_q, ex_mr_q, ex_wr_q, mem_rw_q, mem_wr_q);

    ex_rw_d = bus.ID_RegWrite;
    ex_mr_d = bus.ID_MemRead;
    ex_wr_d = bus.ID_WriteReg;
    sel_a_d = fwd_a;
    sel_b_d = fwd_b;
    if (bus.Flush || stall) begin
      ex_rw_d = 1'b0;
      ex_mr_d = 1'b0;
      ex_wr_d = '0;
      sel_a_d = SEL_REG;
      sel_b_d = SEL_REG;
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rw_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      ex_wr_q  <= '0;
      mem_rw_q <= 1'b0;
      mem_wr_q <= '0;
      sel_a_q  <= SEL_REG;
      sel_b_q  <= SEL_REG;
      cnt_q    <= '0;
    end else if (!bus.Freeze) begin
      mem_rw_q <= ex_rw_q;
      mem_wr_q <= ex_wr_q;
      ex_rw_q  <= ex_rw_d;
      ex_mr_q  <= ex_mr_d;
      ex_wr_q  <= ex_wr_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.Stall       = stall;
  assign bus.AluSrcA_Sel = sel_a_q;
  assign bus.AluSrcB_Sel = sel_b_q;
  assign bus.StallCount  = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Table-driven scoreboard bench for fwd_hazard_ctrl; a 2-bit counter makes saturation reachable.
module tb_fwd_hazard_ctrl;

  localparam int unsigned CNT_W = 2;

  logic clk;
  logic rst;

  fwd_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  fwd_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [4:0] rs, rt;
    logic       urs, urt, rw, mr;
    logic [4:0] wr;
    logic       fl, fz;
    logic       stall;
    logic [1:0] a, b;
    int unsigned cnt;
  } row_t;

  row_t tbl[$];
  row_t exp_q[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic row_t row(
    input string tag,
    input int rs, input int rt, input bit urs, input bit urt,
    input bit rw, input bit mr, input int wr, input bit fl, input bit fz,
    input bit stall, input int a, input int b, input int cnt
  );
    row_t r;
    r.tag = tag;
    r.rs = 5'(rs); r.rt = 5'(rt); r.urs = urs; r.urt = urt;
    r.rw = rw; r.mr = mr; r.wr = 5'(wr); r.fl = fl; r.fz = fz;
    r.stall = stall; r.a = 2'(a); r.b = 2'(b); r.cnt = cnt;
    return r;
  endfunction

  task automatic drive(input row_t r);
    bus.ID_rs       = r.rs;
    bus.ID_rt       = r.rt;
    bus.ID_UsesRs   = r.urs;
    bus.ID_UsesRt   = r.urt;
    bus.ID_RegWrite = r.rw;
    bus.ID_MemRead  = r.mr;
    bus.ID_WriteReg = r.wr;
    bus.Flush       = r.fl;
    bus.Freeze      = r.fz;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stall_obs;
    row_t e;

    //        tag        rs rt urs urt rw mr wr fl fz  stall a  b  cnt
    tbl.push_back(row("add3",    1, 2, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row("sub_rs3", 3, 2, 1, 1, 1, 0, 6, 0, 0, 0, 1, 0, 0));
    tbl.push_back(row("nop1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row("or5",     1, 2, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row("nop2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row("and_rt5", 7, 5, 1, 1, 1, 0, 8, 0, 0, 0, 0, 2, 0));
    tbl.push_back(row("or5b",    0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row("addi5",   5, 0, 1, 0, 1, 0, 5, 0, 0, 0, 1, 0, 0));
    tbl.push_back(row("both5",   5, 5, 1, 1, 1, 0, 9, 0, 0, 0, 1, 1, 0));
    tbl.push_back(row("lw4",     9, 0, 1, 0, 1, 1, 4, 0, 0, 0, 1, 0, 0));
    tbl.push_back(row("lu_stal", 4, 2, 1, 1, 1, 0,10, 0, 0, 1, 0, 0, 1));
    tbl.push_back(row("lu_fwd",  4, 2, 1, 1, 1, 0,10, 0, 0, 0, 2, 0, 1));
    tbl.push_back(row("nop3",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row("wr0",     1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row("rd0",     0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row("lw0",     0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row("rd0_ld",  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row("lw4_f",   0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 1));
    tbl.push_back(row("flush",   4, 0, 1, 0, 1, 0,10, 1, 0, 0, 0, 0, 1));
    tbl.push_back(row("addi11",  4, 0, 1, 0, 1, 0,11, 0, 0, 0, 2, 0, 1));
    tbl.push_back(row("lw4_z",  11, 0, 1, 0, 1, 1, 4, 0, 0, 0, 1, 0, 1));
    tbl.push_back(row("frz1",    4, 2, 1, 1, 1, 0,10, 0, 1, 1, 1, 0, 1));
    tbl.push_back(row("frz2",    4, 2, 1, 1, 1, 0,10, 0, 1, 1, 1, 0, 1));
    tbl.push_back(row("frz3",    4, 2, 1, 1, 1, 0,10, 0, 1, 1, 1, 0, 1));
    tbl.push_back(row("unfrz",   4, 2, 1, 1, 1, 0,10, 0, 0, 1, 0, 0, 2));
    tbl.push_back(row("frz_fwd", 4, 2, 1, 1, 1, 0,10, 0, 0, 0, 2, 0, 2));
    tbl.push_back(row("nop4",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(row("lw4_s1",  0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 2));
    tbl.push_back(row("st_s1",   4, 0, 1, 0, 1, 0,10, 0, 0, 1, 0, 0, 3));
    tbl.push_back(row("fw_s1",   4, 0, 1, 0, 1, 0,10, 0, 0, 0, 2, 0, 3));
    tbl.push_back(row("lw4_s2",  0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 3));
    tbl.push_back(row("st_sat",  0, 4, 0, 1, 1, 0,12, 0, 0, 1, 0, 0, 3));
    tbl.push_back(row("fw_sat",  0, 4, 0, 1, 1, 0,12, 0, 0, 0, 0, 2, 3));

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.ID_rs = 5'($urandom);       bus.ID_rt = 5'($urandom);
      bus.ID_UsesRs = 1'($urandom);   bus.ID_UsesRt = 1'($urandom);
      bus.ID_RegWrite = 1'($urandom); bus.ID_MemRead = 1'($urandom);
      bus.ID_WriteReg = 5'($urandom); bus.Flush = 1'($urandom);
      bus.Freeze = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_selA", 32'(bus.AluSrcA_Sel), 0);
      chk("rst_selB", 32'(bus.AluSrcB_Sel), 0);
      chk("rst_cnt",  32'(bus.StallCount), 0);
      chk("rst_stall", 32'(bus.Stall), 0);
    end
    @(negedge clk);
    drive(row("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      #1 stall_obs = bus.Stall;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk({e.tag, "_stall"}, 32'(stall_obs), 32'(e.stall));
        chk({e.tag, "_selA"},  32'(bus.AluSrcA_Sel), 32'(e.a));
        chk({e.tag, "_selB"},  32'(bus.AluSrcB_Sel), 32'(e.b));
        chk({e.tag, "_cnt"},   32'(bus.StallCount), e.cnt);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
